// File: rtl/lane_train_fsm.sv
// rtl/lane_train_fsm.sv - Gen4 lane initialisation state machine (DISC/TS1/TS2/CL0/DIS) with bounded retry
module lane_train_fsm #(
    parameter int TS1_RX_REQ = 2,
    parameter int TS2_RX_REQ = 2,
    parameter int TS2_TX_MIN = 16,
    parameter int MAX_RETRY  = 3
) (
    input  logic       clk_b,
    input  logic       rst,
    input  logic       disable_req,
    input  logic       tdisconnect_tx_min,
    input  logic       tdisabled_min,
    input  logic       ttraining_error_timeout,
    input  logic       tgen4_ts1_timeout,
    input  logic       tgen4_ts2_timeout,
    input  logic       tconnect_rx_min,
    input  logic       tdisconnect_rx_min,
    input  logic       ts1_rcvd,
    input  logic       ts2_rcvd,
    input  logic       ts_sent,
    output logic       disconnected_s,
    output logic       fsm_disabled,
    output logic       fsm_training,
    output logic       ts1_gen4_s,
    output logic       ts2_gen4_s,
    output logic       cl0_s,
    output logic [1:0] retry_cnt,
    output logic       train_fail
);
    localparam int TS1_W = $clog2(TS1_RX_REQ + 1);
    localparam int TS2_W = $clog2(TS2_RX_REQ + 1);
    localparam int TX_W  = $clog2(TS2_TX_MIN + 1);
    localparam logic [TS1_W-1:0] TS1_MAX = TS1_W'(TS1_RX_REQ);
    localparam logic [TS2_W-1:0] TS2_MAX = TS2_W'(TS2_RX_REQ);
    localparam logic [TX_W-1:0]  TX_MAX  = TX_W'(TS2_TX_MIN);
    localparam logic [1:0]       RETRY_LAST = 2'(MAX_RETRY - 1);

    typedef enum logic [2:0] {DISC, TS1, TS2, CL0, DIS} state_t;

    state_t           state, state_n;
    logic             entry, entry_n;
    logic             txmin_done, txmin_n;
    logic             seen_ts2, seen_n;
    logic [TS1_W-1:0] ts1_cnt, ts1_n;
    logic [TS2_W-1:0] ts2_cnt, ts2_n;
    logic [TX_W-1:0]  tx_cnt, tx_n;
    logic [1:0]       retry_n;
    logic             fail_n;
    logic             reenter;
    logic             training;
    logic             ts_timeout;

    // entry is high for the first cycle of every state; timer expiries are ignored then
    assign training   = (state == TS1) || (state == TS2);
    assign ts_timeout = !entry && (((state == TS1) && tgen4_ts1_timeout) ||
                                   ((state == TS2) && tgen4_ts2_timeout));

    always_comb begin
        state_n = state;
        ts1_n   = ts1_cnt;
        ts2_n   = ts2_cnt;
        tx_n    = tx_cnt;
        seen_n  = seen_ts2;
        txmin_n = 1'b0;
        fail_n  = 1'b0;
        reenter = 1'b0;
        retry_n = ((state == DISC) || (state == CL0)) ? 2'd0 : retry_cnt;

        if (disable_req && (state != DIS)) begin
            state_n = DIS;
        end else if (tdisconnect_rx_min && (training || (state == CL0))) begin
            state_n = DISC;
        end else if (training && ttraining_error_timeout && !entry) begin
            state_n = DISC;
            fail_n  = 1'b1;
        end else if (ts_timeout) begin
            if (retry_cnt == RETRY_LAST) begin
                state_n = DISC;
                fail_n  = 1'b1;
            end else begin
                retry_n = retry_cnt + 2'd1;
                state_n = TS1;
                reenter = 1'b1;
            end
        end else begin
            case (state)
                DISC: begin
                    txmin_n = txmin_done | (tdisconnect_tx_min & ~entry);
                    if (txmin_n && tconnect_rx_min) state_n = TS1;
                end
                TS1: begin
                    if (ts2_rcvd) ts1_n = '0;
                    else if (ts1_rcvd && (ts1_cnt != TS1_MAX)) ts1_n = ts1_cnt + 1'b1;
                    if (int'(ts1_n) >= TS1_RX_REQ) state_n = TS2;
                end
                TS2: begin
                    if (ts2_rcvd && (ts2_cnt != TS2_MAX)) ts2_n = ts2_cnt + 1'b1;
                    seen_n = seen_ts2 | ts2_rcvd;
                    if (ts_sent && seen_n && (tx_cnt != TX_MAX)) tx_n = tx_cnt + 1'b1;
                    if ((int'(ts2_n) >= TS2_RX_REQ) && (int'(tx_n) >= TS2_TX_MIN)) state_n = CL0;
                end
                DIS: begin
                    if (!disable_req && tdisabled_min && !entry) state_n = DISC;
                end
                default: ;
            endcase
        end

        entry_n = (state_n != state) || reenter;
        if (entry_n) begin
            ts1_n   = '0;
            ts2_n   = '0;
            tx_n    = '0;
            seen_n  = 1'b0;
            txmin_n = 1'b0;
        end
    end

    always_ff @(posedge clk_b or negedge rst) begin
        if (!rst) begin
            state      <= DISC;
            entry      <= 1'b0;
            txmin_done <= 1'b0;
            seen_ts2   <= 1'b0;
            ts1_cnt    <= '0;
            ts2_cnt    <= '0;
            tx_cnt     <= '0;
            retry_cnt  <= 2'd0;
            train_fail <= 1'b0;
        end else begin
            state      <= state_n;
            entry      <= entry_n;
            txmin_done <= txmin_n;
            seen_ts2   <= seen_n;
            ts1_cnt    <= ts1_n;
            ts2_cnt    <= ts2_n;
            tx_cnt     <= tx_n;
            retry_cnt  <= retry_n;
            train_fail <= fail_n;
        end
    end

    assign disconnected_s = (state == DISC);
    assign fsm_disabled   = (state == DIS);
    assign fsm_training   = training;
    assign ts1_gen4_s     = (state == TS1);
    assign ts2_gen4_s     = (state == TS2);
    assign cl0_s          = (state == CL0);
endmodule
